// File: rtl/toggle_cover_arbiter.sv
// toggle_cover_arbiter: gathers per-bit toggle hits from NUM_GROUPS 64-bit groups and drains
// them as a round-robin valid/ready index stream. Define TOGGLE_COVER_DEDUP_EN for once-only reporting.
module toggle_cover_arbiter #(
  parameter int NUM_GROUPS  = 4,
  parameter int COVER_INDEX = 0,
  parameter int IDX_W       = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_GROUPS*64-1:0] valid,
  input  logic                     cover_clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IDX_W-1:0]         out_index,
  output logic                     pending_any,
  output logic [31:0]              hit_count
);
  localparam int NBITS = NUM_GROUPS * 64;
  localparam int PTR_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam int SEL_W = $clog2(NBITS);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state_q, state_d;
  logic [NBITS-1:0] pending_q, pending_d;
  logic [NBITS-1:0] load_mask, capture;
  logic [PTR_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      hits_q, hits_d;

  logic             sel_found;
  logic [PTR_W-1:0] sel_group;
  logic [5:0]       sel_bit;
  logic [SEL_W-1:0] sel_pos;
  logic [63:0]      sel_word;
  int               grp_idx;
  logic             load, accept;

  // Rotating search from rr_q for the first group holding any pending bit, then its lowest bit.
  always_comb begin
    sel_found = 1'b0;
    sel_group = '0;
    grp_idx   = 0;
    for (int off = 0; off < NUM_GROUPS; off++) begin
      grp_idx = (int'(rr_q) + off) % NUM_GROUPS;
      if (!sel_found && (|pending_q[grp_idx*64 +: 64])) begin
        sel_found = 1'b1;
        sel_group = PTR_W'(grp_idx);
      end
    end
    sel_word = pending_q[int'(sel_group)*64 +: 64];
    sel_bit  = '0;
    for (int b = 63; b >= 0; b--) begin
      if (sel_word[b]) sel_bit = 6'(b);
    end
    sel_pos = SEL_W'(int'(sel_group) * 64 + int'(sel_bit));
  end

  assign accept = (state_q == FULL) && out_ready;
  assign load   = ((state_q == EMPTY) || out_ready) && sel_found && !cover_clear;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rr_d      = rr_q;
    hits_d    = hits_q;
    load_mask = '0;
    if (accept && (hits_q != 32'hFFFF_FFFF)) hits_d = hits_q + 32'd1;
    if (load) begin
      load_mask[sel_pos] = 1'b1;
      state_d = FULL;
      idx_d   = IDX_W'(COVER_INDEX) + IDX_W'(sel_pos);
      rr_d    = (sel_group == PTR_W'(NUM_GROUPS - 1)) ? '0 : sel_group + PTR_W'(1);
    end else if (accept) begin
      state_d = EMPTY;
    end
    if (cover_clear) rr_d = '0;
  end

`ifdef TOGGLE_COVER_DEDUP_EN
  logic [NBITS-1:0] covered_q, covered_d;

  // The bit loaded this edge already counts as covered, so a same-edge hit on it is dropped.
  always_comb begin
    covered_d = covered_q | load_mask;
    capture   = valid & ~covered_d;
    if (cover_clear) covered_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) covered_q <= '0;
    else       covered_q <= covered_d;
  end
`else
  assign capture = valid;
`endif

  assign pending_d = cover_clear ? '0 : ((pending_q & ~load_mask) | capture);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= EMPTY;
      pending_q <= '0;
      rr_q      <= '0;
      idx_q     <= '0;
      hits_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rr_q      <= rr_d;
      idx_q     <= idx_d;
      hits_q    <= hits_d;
    end
  end

  assign out_valid   = (state_q == FULL);
  assign out_index   = idx_q;
  assign pending_any = |pending_q;
  assign hit_count   = hits_q;
endmodule

// File: tb/tb_toggle_cover_arbiter.sv
// tb_toggle_cover_arbiter: directed and randomized checks of toggle_cover_arbiter against
// a bit-array behavioural model; honours TOGGLE_COVER_DEDUP_EN the same way as the design.
`timescale 1ns/1ps
module tb_toggle_cover_arbiter;
  localparam int NG = 4;
  localparam int CI = 1000;
  localparam int IW = 32;
  localparam int N  = NG * 64;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  valid = '0;
  logic          coverClear = 1'b0;
  logic          outReady = 1'b0;
  logic          outValid;
  logic [IW-1:0] outIndex;
  logic          pendingAny;
  logic [31:0]   hitCount;

  int checks = 0;
  int errors = 0;

  bit     mPend[N];
  bit     mCov[N];
  int     mRr;
  bit     mValid;
  int     mIdx;
  longint mHits;

  toggle_cover_arbiter #(.NUM_GROUPS(NG), .COVER_INDEX(CI), .IDX_W(IW)) dut (
    .clock(clock), .reset(reset), .valid(valid), .cover_clear(coverClear),
    .out_valid(outValid), .out_ready(outReady), .out_index(outIndex),
    .pending_any(pendingAny), .hit_count(hitCount)
  );

  always #5 clock = ~clock;

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkEq(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    foreach (mPend[i]) begin
      mPend[i] = 1'b0;
      mCov[i]  = 1'b0;
    end
    mRr = 0; mValid = 1'b0; mIdx = 0; mHits = 0;
  endtask

  function automatic bit modelAny();
    foreach (mPend[i]) if (mPend[i]) return 1'b1;
    return 1'b0;
  endfunction

  // One rising edge of the reference: handshake, pick/load, then capture of this cycle's hits.
  task automatic modelStep();
    bit accept, found;
    int sel;
    if (reset) begin
      modelReset();
      return;
    end
    accept = mValid && outReady;
    if (accept && mHits < 64'hFFFF_FFFF) mHits++;
    found = 1'b0;
    sel = 0;
    if ((!mValid || outReady) && !coverClear) begin
      for (int off = 0; off < NG && !found; off++) begin
        int g = (mRr + off) % NG;
        for (int b = 0; b < 64 && !found; b++) begin
          if (mPend[g*64+b]) begin
            found = 1'b1;
            sel = g*64 + b;
            mRr = (g + 1) % NG;
          end
        end
      end
    end
    if (found) begin
      mPend[sel] = 1'b0;
      mCov[sel]  = 1'b1;
      mValid = 1'b1;
      mIdx = CI + sel;
    end else if (accept) begin
      mValid = 1'b0;
    end
    if (coverClear) begin
      modelReset0();
    end else begin
      for (int i = 0; i < N; i++) begin
`ifdef TOGGLE_COVER_DEDUP_EN
        if (valid[i] && !mCov[i]) mPend[i] = 1'b1;
`else
        if (valid[i]) mPend[i] = 1'b1;
`endif
      end
    end
  endtask

  task automatic modelReset0();
    foreach (mPend[i]) begin
      mPend[i] = 1'b0;
      mCov[i]  = 1'b0;
    end
    mRr = 0;
  endtask

  task automatic checkOutput();
    checkEq("out_valid", outValid, mValid);
    if (mValid) checkEq("out_index", outIndex, mIdx);
    checkEq("pending_any", pendingAny, modelAny());
    checkEq("hit_count", hitCount, mHits);
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic rdy, input logic clr);
    valid = v;
    outReady = rdy;
    coverClear = clr;
  endtask

  task automatic stepCycle();
    @(posedge clock);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic resetDut();
    reset = 1'b1;
    applyStimulus('0, 1'b0, 1'b0);
    #1;
    modelReset();
    stepCycle();
    stepCycle();
    reset = 1'b0;
    stepCycle();
  endtask

  function automatic logic [N-1:0] bitAt(input int i);
    logic [N-1:0] v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  initial begin
    logic [N-1:0] v;
    int expSeq[5];
    int dedupFirst, dedupSecond;
    modelReset();
    #1;
    checkEq("reset out_valid", outValid, 0);
    checkEq("reset out_index", outIndex, 0);
    checkEq("reset pending_any", pendingAny, 0);
    checkEq("reset hit_count", hitCount, 0);
    resetDut();

    // Single hit: visible two edges after capture, then accepted.
    applyStimulus(bitAt(5), 1'b1, 1'b0);
    stepCycle();
    applyStimulus('0, 1'b1, 1'b0);
    checkEq("lat edge1 out_valid", outValid, 0);
    stepCycle();
    checkEq("lat edge2 out_valid", outValid, 1);
    checkEq("lat edge2 out_index", outIndex, CI + 5);
    stepCycle();
    checkEq("lat edge3 hit_count", hitCount, 1);
    checkEq("lat edge3 out_valid", outValid, 0);

    // Three groups hit together drain in group order from a zero pointer.
    resetDut();
    applyStimulus(bitAt(3) | bitAt(64) | bitAt(191), 1'b1, 1'b0);
    stepCycle();
    applyStimulus('0, 1'b1, 1'b0);
    stepCycle();
    checkEq("rr idx0", outIndex, CI + 3);
    stepCycle();
    checkEq("rr idx1", outIndex, CI + 64);
    stepCycle();
    checkEq("rr idx2", outIndex, CI + 191);
    stepCycle();
    checkEq("rr count", hitCount, 3);

    // Back-pressure holds the presented index.
    resetDut();
    applyStimulus(bitAt(10), 1'b0, 1'b0);
    stepCycle();
    applyStimulus('0, 1'b0, 1'b0);
    stepCycle();
    for (int i = 0; i < 10; i++) begin
      stepCycle();
      checkEq("stall out_index", outIndex, CI + 10);
      checkEq("stall hit_count", hitCount, 0);
    end
    applyStimulus('0, 1'b1, 1'b0);
    stepCycle();
    checkEq("stall release count", hitCount, 1);
    checkEq("stall release valid", outValid, 0);
    stepCycle();
    checkEq("stall once", hitCount, 1);

    // Repeated pulses on one bit, then cover_clear and another pulse.
`ifdef TOGGLE_COVER_DEDUP_EN
    dedupFirst = 1; dedupSecond = 2;
`else
    dedupFirst = 5; dedupSecond = 6;
`endif
    resetDut();
    for (int i = 0; i < 24; i++) begin
      applyStimulus((i % 4 == 0 && i < 20) ? bitAt(7) : '0, 1'b1, 1'b0);
      stepCycle();
    end
    checkEq("dedup first count", hitCount, dedupFirst);
    applyStimulus('0, 1'b1, 1'b1);
    stepCycle();
    applyStimulus(bitAt(7), 1'b1, 1'b0);
    stepCycle();
    applyStimulus('0, 1'b1, 1'b0);
    repeat (4) stepCycle();
    checkEq("dedup after clear count", hitCount, dedupSecond);

    // Reset while an index is presented and stalled.
    resetDut();
    applyStimulus(bitAt(2), 1'b1, 1'b0);
    stepCycle();
    applyStimulus('0, 1'b1, 1'b0);
    repeat (2) stepCycle();
    applyStimulus(bitAt(9), 1'b0, 1'b0);
    stepCycle();
    applyStimulus('0, 1'b0, 1'b0);
    stepCycle();
    checkEq("pre-reset out_valid", outValid, 1);
    checkEq("pre-reset hit_count", hitCount, 1);
    #2 reset = 1'b1;
    #1;
    checkEq("async reset out_valid", outValid, 0);
    checkEq("async reset hit_count", hitCount, 0);
    modelReset();
    stepCycle();
    reset = 1'b0;
    applyStimulus('0, 1'b1, 1'b0);
    repeat (3) stepCycle();
    checkEq("no stale index", outValid, 0);

    // Every bit hit at once.
    resetDut();
    expSeq = '{CI + 0, CI + 64, CI + 128, CI + 192, CI + 1};
    applyStimulus('1, 1'b1, 1'b0);
    stepCycle();
    applyStimulus('0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      checkEq("all-hit order", outIndex, expSeq[i]);
    end
    repeat (N) stepCycle();
    checkEq("all-hit count", hitCount, N);
    checkEq("all-hit drained", outValid, 0);

    // Randomized traffic.
    resetDut();
    for (int c = 0; c < 4000; c++) begin
      v = '0;
      if ($urandom % 3 == 0) begin
        repeat (1 + $urandom % 3) v[$urandom % N] = 1'b1;
      end
      if ($urandom % 60 == 0) v[($urandom % NG)*64 +: 64] = {$urandom, $urandom};
      applyStimulus(v, ($urandom % 4) != 0, ($urandom % 100) == 0);
      reset = (($urandom % 700) == 0);
      stepCycle();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
